// File: rtl/deaggregator_pkg.sv
// ============================================================================
//  Module      : deaggregator_pkg
//  Description : Shared definitions for the deaggregator slice.
//                - FSM state type and encodings (DEAGG_IDLE / DEAGG_DRAIN)
//                - width helper for counters that must be at least 1 bit
//                - DEAGG_ELEM element-slice helper macro
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package deaggregator_pkg;

    // One-bit state register; encodings kept as plain constants so legacy
    // code comparing against 1'b0 / 1'b1 keeps working.
    typedef logic [0:0] deagg_state_t;

    localparam deagg_state_t DEAGG_IDLE  = 1'b0;
    localparam deagg_state_t DEAGG_DRAIN = 1'b1;

    // $clog2(n), but never less than one bit so that counters for n == 1
    // still have a legal declaration.
    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : deaggregator_pkg

// Element k of a packed vector of w-bit elements (element 0 in the LSBs).
`ifndef DEAGG_ELEM
`define DEAGG_ELEM(vec, k, w) vec[(k)*(w) +: (w)]
`endif

`default_nettype wire

// File: rtl/deaggregator_ii_gap_timer.sv
// ============================================================================
//  Module      : ii_gap_timer
//  Description : Initiation-interval spacer. A pulse on load arms a down
//                counter with II-1; done is high whenever the counter is 0.
//                The counter decrements every cycle regardless of any
//                downstream stall. With II == 1 done is constantly high and
//                no state is kept.
//  Ports       : clk   clock
//                rst   synchronous active-high reset (counter -> 0)
//                load  an element was just handed off; start a new gap
//                done  no gap pending, the next element may be offered
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ii_gap_timer
    import deaggregator_pkg::*;
#(
    parameter int II = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    if (II > 1) begin : g_paced
        localparam int GW = width_min1(II);

        logic [GW-1:0] gap_q;
        logic [GW-1:0] gap_d;

        always_comb begin
            gap_d = gap_q;
            if (load) begin
                gap_d = GW'(II - 1);
            end else if (gap_q != '0) begin
                gap_d = gap_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_d;
            end
        end

        assign done = (gap_q == '0);
    end else begin : g_unpaced
        // No spacing: every cycle is eligible. Inputs are intentionally
        // left unconsumed in this configuration.
        logic unused_ok;
        assign unused_ok = ^{clk, rst, load};
        assign done      = 1'b1;
    end

endmodule : ii_gap_timer

`default_nettype wire

// File: rtl/deaggregator.sv
// ============================================================================
//  Module      : deaggregator
//  Description : Parallel-to-serial unpacker. Accepts one N_INS*WIDTH word
//                and emits its elements one per output handshake, element 0
//                first, with at least II cycles between output handshakes.
//                Optional build macro DEAGG_SKID_EN adds a second word
//                register so the next word can be accepted while draining.
//  Ports       : clk        clock
//                rst        synchronous active-high reset
//                in_valid   input word valid
//                in_ready   a word can be accepted this cycle
//                in         packed word, element k = in[(k+1)*WIDTH-1 -: WIDTH]
//                out_valid  out holds a valid element
//                out_ready  downstream accepts the element
//                out        current element
//                out_last   out is element N_INS-1 of its word
//                busy       a word is held and not fully drained
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module deaggregator
    import deaggregator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_INS = 4,
    parameter int II    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_INS*WIDTH-1:0] in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_last,
    output logic                   busy
);

    localparam int            IW       = width_min1(N_INS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_INS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    deagg_state_t             state_q, state_d;
    logic [IW-1:0]            idx_q,   idx_d;
    logic [N_INS*WIDTH-1:0]   word_q,  word_d;

    logic                     w_gap_done;
    logic                     w_out_hs;
    logic                     w_last_hs;
    logic                     w_in_hs;
    logic                     w_load_main;
    logic [N_INS*WIDTH-1:0]   w_load_data;

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    assign out_valid = (state_q == DEAGG_DRAIN) && w_gap_done;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out       = `DEAGG_ELEM(word_q, idx_q, WIDTH);

    assign w_out_hs  = out_valid && out_ready;
    assign w_last_hs = w_out_hs && out_last;
    assign w_in_hs   = in_valid && in_ready;

    // A gap is only started between elements of the same word; a freshly
    // loaded word always starts with its first element immediately.
    ii_gap_timer #(
        .II   (II)
    ) u_gap (
        .clk  (clk),
        .rst  (rst),
        .load (w_out_hs && !out_last),
        .done (w_gap_done)
    );

`ifdef DEAGG_SKID_EN
    // ------------------------------------------------------------------
    // Skid word: decouples acceptance from the drain of the main word.
    // ------------------------------------------------------------------
    logic [N_INS*WIDTH-1:0]   skid_q,      skid_d;
    logic                     skid_full_q, skid_full_d;
    logic                     w_from_skid;

    assign in_ready    = !rst && !skid_full_q;
    assign busy        = (state_q == DEAGG_DRAIN) || skid_full_q;

    // On the last element, a parked word takes priority. in_ready is low
    // whenever the skid is full, so the two sources never compete. With an
    // empty skid a word arriving on the last handshake bypasses it, which
    // keeps the stream free of bubbles.
    assign w_from_skid = w_last_hs && skid_full_q;
    assign w_load_main = w_from_skid ||
                         (w_in_hs && ((state_q == DEAGG_IDLE) || w_last_hs));
    assign w_load_data = w_from_skid ? skid_q : in;

    always_comb begin
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (w_from_skid) begin
            skid_full_d = 1'b0;
        end else if (w_in_hs && (state_q == DEAGG_DRAIN) && !w_last_hs) begin
            skid_d      = in;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    // ------------------------------------------------------------------
    // Single word register: a new word can only enter while idle or in
    // the same cycle the last element leaves. The DRAIN term is a
    // combinational path from out_ready, which is what lets back-to-back
    // words stream with no gap.
    // ------------------------------------------------------------------
    assign in_ready    = !rst &&
                         ((state_q == DEAGG_IDLE) || w_last_hs);
    assign busy        = (state_q == DEAGG_DRAIN);
    assign w_load_main = w_in_hs;
    assign w_load_data = in;
`endif

    // ------------------------------------------------------------------
    // Main word / index / FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;

        if (w_out_hs && !out_last) begin
            idx_d = idx_q + 1'b1;
        end

        if (w_last_hs) begin
            state_d = DEAGG_IDLE;
        end

        // Loading overrides the drain bookkeeping above: a word that
        // replaces the finished one restarts at element 0.
        if (w_load_main) begin
            word_d  = w_load_data;
            idx_d   = '0;
            state_d = DEAGG_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEAGG_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

endmodule : deaggregator

`default_nettype wire

// File: doc/deaggregator.md
Name: deaggregator

Overview:
- Parallel-to-serial unpacker. Accepts one wide word of N_INS elements and emits the elements one at a time, lowest element first.
- Sits directly downstream of single_port_sram, or of any block producing N_INS*WIDTH words, and feeds per-element compute stages.
- Mirror of the aggregator stage.
- Optional initiation-interval spacing between emitted elements.

Parameters:
- WIDTH, 16, bits per element.
- N_INS, 4, elements per input word; N_INS >= 1.
- II, 1, minimum cycles between successive output handshakes; II >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word this cycle.
- in  input  N_INS*WIDTH  packed word; element k = in[(k+1)*WIDTH-1 : k*WIDTH].
- out_valid  output  1  out holds a valid element.
- out_ready  input  1  downstream accepts the element.
- out  output  WIDTH  current element.
- out_last  output  1  out is element N_INS-1 of its word; qualified by out_valid.
- busy  output  1  a word is held and not fully drained.

Behaviour:
- Reset, synchronous and active-high:
  - state = IDLE, idx = 0, gap = 0, word register = 0.
  - out_valid = 0, out_last = 0, busy = 0, out = 0.
  - in_ready = 0 in any cycle where rst is high.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
  - DRAIN: element emission.
- Input handshake (in_valid & in_ready):
  - Latch in into the word register.
  - idx <= 0, gap <= 0, state <= DRAIN.
- DRAIN:
  - out_valid = (gap == 0).
  - out = word[idx].
  - out_last = out_valid & (idx == N_INS-1).
  - busy = 1.
- Output handshake (out_valid & out_ready), not last: idx <= idx+1, gap <= II-1.
- Output handshake on last element:
  - If in_valid is high in the same cycle, load the new word and stay in DRAIN with idx = 0 and gap = 0. There is no bubble when II = 1.
  - Otherwise state <= IDLE.
- in_ready in DRAIN = out_valid & out_ready & out_last. This is a combinational path from out_ready; it is a required behaviour.
- Gap counter:
  - When gap != 0, decrement by 1 every cycle, independent of out_ready.
  - II = 1 means gap is always 0.
- Backpressure: out and out_last are stable while out_valid & !out_ready. idx does not advance.
- Latency: first element valid 1 cycle after input handshake. N_INS elements take at least N_INS*II cycles.
- N_INS = 1: every element has out_last = 1. Back-to-back words at one per cycle.
- Widths: idx is $clog2(N_INS) bits, minimum 1. gap is $clog2(II) bits, minimum 1. No wrap beyond N_INS-1.
- Reset mid-DRAIN: the held word is discarded. Next cycle is IDLE with all outputs at reset values.
- in_valid while in_ready = 0 is ignored. Upstream holds in and in_valid until accepted.

Optional Feature:
- Macro: DEAGG_SKID_EN.
- When defined:
  - A second word register (skid) is added.
  - in_ready = !skid_full, including during DRAIN.
  - A word accepted during DRAIN goes to skid.
  - On the last-element handshake, skid moves to the main register with idx = 0 and skid_full <= 0.
  - skid_full resets to 0. busy = main held | skid_full.
- When undefined: in_ready follows the Behaviour rules above exactly.

Decomposition:
- Shared header deagg_defs.vh:
  - FSM state encodings DEAGG_IDLE = 1'b0, DEAGG_DRAIN = 1'b1.
  - Element-slice helper macro.
- One sub-module: ii_gap_timer. It has clk, rst, load, and a done output. It owns the gap counter, with II as a parameter. It is reusable by other II-paced stages.

Test Plan:
1. WIDTH=8, N_INS=4, II=1, out_ready=1, in=32'h44332211 -> out 11,22,33,44 on 4 consecutive cycles starting 1 cycle after handshake; out_last only with 44; busy drops the cycle after.
2. Same word, out_ready low on cycles 2-3 -> out holds 22 with out_valid=1 through the stall; the sequence completes as 11,22,33,44 with no loss or duplication.
3. II=3, in=32'hDDCCBBAA, out_ready=1 -> handshakes exactly 3 cycles apart (AA at t, BB at t+3, CC at t+6, DD at t+9); out_valid low in between.
4. Back-to-back words 32'h04030201 then 32'h08070605, in_valid held, II=1 -> 8 consecutive elements 01..08; in_ready high only in the cycle of the 04 handshake.
5. rst asserted while idx=2 of 32'h44332211 -> next cycle out_valid=0, busy=0, in_ready=1; a new word 32'hA4A3A2A1 then emits from A1.
6. DEAGG_SKID_EN defined, second word offered during drain -> accepted immediately (in_ready=1 while skid empty); outputs continue without a bubble; in_ready=0 while both registers are full.
